periph_bus_ctrl: RTL and testbench
==================================

Name: periph_bus_ctrl

Overview:
- Parametrised memory-mapped peripheral interconnect between the core data bus and N_SLOTS peripheral slots.
- Decodes word-aligned addresses into per-slot strobes and holds each transfer until the slot acks, with an optional timeout.
- Registers the read data; reports ready/err per transfer.
- Aggregates per-slot interrupt sources into a masked, latched irq line, with three internal control registers above the slot range.

Parameters:
N_SLOTS, 8, number of external peripheral slots (1..16); slot k at byte address 4*k
AW, 6, byte address width; must satisfy 2^AW >= 4*(N_SLOTS+3)
TIMEOUT, 255, cycles a slot may take to ack before the transfer errors (1..65535)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
A  in  AW  byte address; A[1:0] ignored
WD  in  32  write data
WE  in  1  write request (single-cycle pulse or level)
RE  in  1  read request
RD  out  32  registered read data, valid when ready=1
ready  out  1  one-cycle transfer-complete pulse
err  out  1  qualifies ready: unmapped address or timeout
busy  out  1  high from acceptance until the ready cycle
slv_wd  out  32  captured write data, broadcast to all slots
slv_we  out  N_SLOTS  one-hot write strobe, held until ack
slv_re  out  N_SLOTS  one-hot read strobe, held until ack
slv_rd  in  32*N_SLOTS  slot read data, slot k at [32k+31:32k]
slv_ack  in  N_SLOTS  slot completion; sampled only for the active slot
irq_src  in  N_SLOTS  level interrupt requests from slots
irq  out  1  OR of (IRQ_PEND & IRQ_MASK), registered

Behaviour:
- Reset: state IDLE; RD=0, ready=0, err=0, busy=0, slv_we=0, slv_re=0, slv_wd=0; IRQ_PEND=0, IRQ_MASK=0, ERR_CNT=0, irq=0, edge history=0.
- Word index W = A[AW-1:2]. W<N_SLOTS selects a slot. W=N_SLOTS is IRQ_PEND, W=N_SLOTS+1 is IRQ_MASK, W=N_SLOTS+2 is BUS_STAT. Any other W is unmapped.
- FSM states: IDLE, WAIT, RESP.
- IDLE: a request is accepted when WE|RE=1. On acceptance, W, op and WD are captured. WE and RE together is treated as a write.
- IDLE transitions:
  - Slot address -> WAIT, with the strobe asserted from the next cycle.
  - Internal register -> RESP; the access takes effect on the acceptance edge.
  - Unmapped address -> RESP with err=1 and RD=0.
- WAIT: the strobe is held. On slv_ack[slot]=1, RD<=slv_rd[slot] (RD=0 for writes) and the state moves to RESP.
- WAIT timeout: the timeout counter counts WAIT cycles. When it reaches TIMEOUT with no ack, the state moves to RESP with err=1, RD=0, and the strobe is dropped.
- RESP: ready=1 for exactly one cycle, err as determined above, then IDLE. Requests presented during WAIT/RESP are ignored; the master re-presents after ready.
- Latency, request to ready:
  - Slot access: 2 cycles minimum (ack in first WAIT cycle), TIMEOUT+1 cycles maximum.
  - Internal or unmapped access: 1 cycle.
- A late ack arriving in IDLE after a timeout is ignored.
- IRQ_PEND[k] is set on a rising edge of irq_src[k]. A write to IRQ_PEND clears bits written as 1. Set wins over clear in the same cycle.
- IRQ_MASK: plain read/write, bits N_SLOTS-1:0. Upper bits read 0.
- BUS_STAT: [15:0] is ERR_CNT, which increments on each err response and saturates at 0xFFFF. [20:16] is the last errored W. Any write clears both fields.
- irq updates one cycle after PEND/MASK change.
- rst_n asserted mid-transfer aborts it immediately; no ready is issued.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: timeout counter and timeout err exist as specified above.
- Undefined: no counter is built; WAIT persists until ack. err is raised only for unmapped addresses, and TIMEOUT is unused.

Decomposition:
- Package periph_bus_pkg holds:
  - FSM state typedef (IDLE/WAIT/RESP).
  - Internal register offset constants (PEND=0, MASK=1, STAT=2 relative to N_SLOTS).
  - ERR_CNT_MAX constant (0xFFFF).
- Sub-module periph_irq_ctrl: edge detect, PEND/MASK registers, irq output. Driven by write-enable and data from the bus FSM.

Test Plan:
- N_SLOTS=8. Write 0x1234 to A=0x0C, slot 3 acks after 3 cycles -> slv_we=0x08 held for 3 cycles, slv_wd=0x1234, ready 1 cycle later, err=0.
- Read A=0x04, slot 1 acks immediately with 0xCAFEF00D -> ready on the 2nd cycle after request, RD=0xCAFEF00D, err=0.
- BUS_TIMEOUT_EN defined, TIMEOUT=4, read slot 2 with no ack -> ready with err=1, RD=0 exactly 5 cycles after request; BUS_STAT reads 0x00020001.
- Read A=0x3C (unmapped) -> ready next cycle, err=1, no slv strobes; ERR_CNT increments.
- IRQ_MASK=0x05, irq_src[2] rises -> IRQ_PEND=0x04, irq=1 next cycle. Writing 0x04 to IRQ_PEND while irq_src[0] rises gives PEND=0x01 and irq stays 1.
- Assert rst_n low during WAIT -> all strobes 0 immediately, no ready pulse, FSM in IDLE after release.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus controller.
// Holds the transfer FSM state type, the word offsets of the internal
// control registers (relative to N_SLOTS) and the BUS_STAT field layout.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    // Internal register word offsets above the slot range
    localparam int unsigned REG_PEND = 0;
    localparam int unsigned REG_MASK = 1;
    localparam int unsigned REG_STAT = 2;

    // BUS_STAT layout: [15:0] error count, [20:16] last errored word index
    localparam int unsigned ERR_CNT_W   = 16;
    localparam int unsigned STAT_W_BITS = 5;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/periph_bus_ctrl_irq.sv
// Interrupt aggregation for the peripheral bus controller.
// Rising-edge detects each slot's level interrupt into IRQ_PEND, holds the
// IRQ_MASK register and drives a registered irq = |(PEND & MASK).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   irq_src_i    level interrupt requests from the slots
//   pend_we_i    write strobe for IRQ_PEND (write-1-to-clear)
//   mask_we_i    write strobe for IRQ_MASK
//   wdata_i      write data for either register
//   pend_o       current IRQ_PEND
//   mask_o       current IRQ_MASK
//   irq_o        registered aggregated interrupt
module periph_irq_ctrl #(
    parameter int unsigned N_SLOTS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SLOTS-1:0] irq_src_i,
    input  logic               pend_we_i,
    input  logic               mask_we_i,
    input  logic [N_SLOTS-1:0] wdata_i,
    output logic [N_SLOTS-1:0] pend_o,
    output logic [N_SLOTS-1:0] mask_o,
    output logic               irq_o
);

    logic [N_SLOTS-1:0] src_q;
    logic [N_SLOTS-1:0] pend_q, pend_d;
    logic [N_SLOTS-1:0] mask_q, mask_d;
    logic [N_SLOTS-1:0] rise_c;
    logic               irq_q;

    // Clear-on-write is applied first so a coincident rising edge wins
    always_comb begin
        rise_c = irq_src_i & ~src_q;
        pend_d = pend_q;
        mask_d = mask_q;
        if (pend_we_i) begin
            pend_d = pend_q & ~wdata_i;
        end
        pend_d = pend_d | rise_c;
        if (mask_we_i) begin
            mask_d = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            src_q  <= irq_src_i;
            pend_q <= pend_d;
            mask_q <= mask_d;
            irq_q  <= |(pend_q & mask_q);
        end
    end

    assign pend_o = pend_q;
    assign mask_o = mask_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/periph_bus_ctrl.sv
// Memory-mapped interconnect between the core data bus and N_SLOTS
// peripheral slots plus three internal registers (IRQ_PEND, IRQ_MASK,
// BUS_STAT) directly above the slot range.
// Optional feature macro: BUS_TIMEOUT_EN -- when defined, a slot that does
// not ack within TIMEOUT WAIT cycles completes with err=1.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   A, WD, WE, RE       core request: byte address, write data, write/read
//   RD, ready, err      registered response (ready is a 1-cycle pulse)
//   busy                high from acceptance through the ready cycle
//   slv_wd              captured write data broadcast to all slots
//   slv_we, slv_re      one-hot slot strobes, held until ack
//   slv_rd, slv_ack     slot read data (32 bits per slot) and completion
//   irq_src, irq        slot interrupt levels, aggregated registered irq
module periph_bus_ctrl
    import periph_bus_pkg::*;
#(
    parameter int unsigned N_SLOTS = 8,
    parameter int unsigned AW      = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         A,
    input  logic [31:0]           WD,
    input  logic                  WE,
    input  logic                  RE,
    output logic [31:0]           RD,
    output logic                  ready,
    output logic                  err,
    output logic                  busy,
    output logic [31:0]           slv_wd,
    output logic [N_SLOTS-1:0]    slv_we,
    output logic [N_SLOTS-1:0]    slv_re,
    input  logic [32*N_SLOTS-1:0] slv_rd,
    input  logic [N_SLOTS-1:0]    slv_ack,
    input  logic [N_SLOTS-1:0]    irq_src,
    output logic                  irq
);

    localparam int unsigned DW     = 32;
    localparam int unsigned WW     = AW - 2;
    localparam int unsigned W_PEND = N_SLOTS + REG_PEND;
    localparam int unsigned W_MASK = N_SLOTS + REG_MASK;
    localparam int unsigned W_STAT = N_SLOTS + REG_STAT;

    bus_state_e state_q, state_d;

    logic                   wr_q, wr_d;
    logic [N_SLOTS-1:0]     sel_q, sel_d;
    logic [WW-1:0]          w_q, w_d;
    logic [DW-1:0]          wd_q, wd_d;
    logic [DW-1:0]          rd_q, rd_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic [N_SLOTS-1:0]     slv_we_q, we_d;
    logic [N_SLOTS-1:0]     slv_re_q, re_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [STAT_W_BITS-1:0] last_w_q, last_w_d;

    logic [WW-1:0]          w_c;
    logic [31:0]            w32_c;
    logic                   req_c;
    logic                   is_slot_c, is_pend_c, is_mask_c, is_stat_c;
    logic [N_SLOTS-1:0]     onehot_c;
    logic                   ack_c;
    logic [DW-1:0]          slot_rd_c;
    logic [DW-1:0]          reg_rd_c;
    logic                   pend_we_c, mask_we_c;
    logic                   log_err_c;
    logic [WW-1:0]          err_w_c;
    logic [N_SLOTS-1:0]     pend_c, mask_c;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW = 16;
    logic [TW-1:0] tmo_q, tmo_d;
    logic unused_bits;
    assign unused_bits = ^A[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{A[1:0], 32'(TIMEOUT)};
`endif

    // Word-index decode of the incoming address
    always_comb begin
        w_c       = A[AW-1:2];
        w32_c     = 32'(w_c);
        req_c     = WE | RE;
        is_slot_c = (w32_c < N_SLOTS);
        is_pend_c = (w32_c == W_PEND);
        is_mask_c = (w32_c == W_MASK);
        is_stat_c = (w32_c == W_STAT);
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            onehot_c[k] = (w32_c == k);
        end
    end

    // Only the captured slot's ack and read data are ever looked at
    always_comb begin
        ack_c     = |(slv_ack & sel_q);
        slot_rd_c = '0;
        for (int unsigned k = 0; k < N_SLOTS; k++) begin
            if (sel_q[k]) begin
                slot_rd_c = slot_rd_c | slv_rd[DW*k +: DW];
            end
        end
    end

    // Internal register read mux
    always_comb begin
        reg_rd_c = '0;
        if (is_pend_c) begin
            reg_rd_c = DW'(pend_c);
        end else if (is_mask_c) begin
            reg_rd_c = DW'(mask_c);
        end else if (is_stat_c) begin
            reg_rd_c = {11'd0, last_w_q, err_cnt_q};
        end
    end

    // Transfer FSM: next state and all registered outputs
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        sel_d     = sel_q;
        w_d       = w_q;
        wd_d      = wd_q;
        rd_d      = rd_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        busy_d    = busy_q;
        we_d      = slv_we_q;
        re_d      = slv_re_q;
        err_cnt_d = err_cnt_q;
        last_w_d  = last_w_q;
        pend_we_c = 1'b0;
        mask_we_c = 1'b0;
        log_err_c = 1'b0;
        err_w_c   = w_q;
`ifdef BUS_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                err_w_c = w_c;
                if (req_c) begin
                    // WE wins when both are presented
                    wr_d   = WE;
                    w_d    = w_c;
                    wd_d   = WD;
                    busy_d = 1'b1;
                    if (is_slot_c) begin
                        sel_d   = onehot_c;
                        we_d    = WE ? onehot_c : '0;
                        re_d    = WE ? '0 : onehot_c;
                        state_d = WAIT;
`ifdef BUS_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else if (is_pend_c || is_mask_c || is_stat_c) begin
                        state_d   = RESP;
                        ready_d   = 1'b1;
                        rd_d      = WE ? '0 : reg_rd_c;
                        pend_we_c = WE & is_pend_c;
                        mask_we_c = WE & is_mask_c;
                        if (WE && is_stat_c) begin
                            err_cnt_d = '0;
                            last_w_d  = '0;
                        end
                    end else begin
                        state_d   = RESP;
                        ready_d   = 1'b1;
                        err_d     = 1'b1;
                        rd_d      = '0;
                        log_err_c = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (ack_c) begin
                    rd_d    = wr_q ? '0 : slot_rd_c;
                    we_d    = '0;
                    re_d    = '0;
                    state_d = RESP;
                    ready_d = 1'b1;
`ifdef BUS_TIMEOUT_EN
                // Ack in the final allowed cycle still completes cleanly
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rd_d      = '0;
                    we_d      = '0;
                    re_d      = '0;
                    state_d   = RESP;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    log_err_c = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                we_d    = '0;
                re_d    = '0;
            end
        endcase

        // Error statistics: saturating count plus the offending word index
        if (log_err_c) begin
            if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            last_w_d = STAT_W_BITS'(err_w_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            sel_q     <= '0;
            w_q       <= '0;
            wd_q      <= '0;
            rd_q      <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            slv_we_q  <= '0;
            slv_re_q  <= '0;
            err_cnt_q <= '0;
            last_w_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            sel_q     <= sel_d;
            w_q       <= w_d;
            wd_q      <= wd_d;
            rd_q      <= rd_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            slv_we_q  <= we_d;
            slv_re_q  <= re_d;
            err_cnt_q <= err_cnt_d;
            last_w_q  <= last_w_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    periph_irq_ctrl #(
        .N_SLOTS (N_SLOTS)
    ) u_irq (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src_i (irq_src),
        .pend_we_i (pend_we_c),
        .mask_we_i (mask_we_c),
        .wdata_i   (WD[N_SLOTS-1:0]),
        .pend_o    (pend_c),
        .mask_o    (mask_c),
        .irq_o     (irq)
    );

    assign RD     = rd_q;
    assign ready  = ready_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign slv_wd = wd_q;
    assign slv_we = slv_we_q;
    assign slv_re = slv_re_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Scoreboard bench for periph_bus_ctrl (N_SLOTS=8, AW=6, TIMEOUT=4).
// A transaction-level model predicts each response; a monitor pops and
// compares on every ready pulse; a slot responder acks after a chosen delay.
module tb_periph_bus_ctrl;

    localparam int unsigned NS  = 8;
    localparam int unsigned AWP = 6;
    localparam int unsigned TMO = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AWP-1:0]    A;
    logic [31:0]       WD;
    logic              WE, RE;
    logic [31:0]       RD;
    logic              ready, err, busy;
    logic [31:0]       slv_wd;
    logic [NS-1:0]     slv_we, slv_re;
    logic [32*NS-1:0]  slv_rd;
    logic [NS-1:0]     slv_ack;
    logic [NS-1:0]     irq_src;
    logic              irq;

    periph_bus_ctrl #(.N_SLOTS(NS), .AW(AWP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .RE(RE),
        .RD(RD), .ready(ready), .err(err), .busy(busy),
        .slv_wd(slv_wd), .slv_we(slv_we), .slv_re(slv_re),
        .slv_rd(slv_rd), .slv_ack(slv_ack), .irq_src(irq_src), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_bench();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state
    logic [7:0]  pend_m, mask_m;
    logic [15:0] ecnt_m;
    logic [4:0]  lastw_m;

    // Slot responder configuration for the current transaction
    logic [NS-1:0] rsp_mask = '0;
    logic          rsp_wr   = 1'b0;
    logic [31:0]   rsp_wd   = '0;
    logic [31:0]   rsp_data = '0;
    int            rsp_delay = 0;
    int            rsp_cnt   = 0;
    int            rsp_held  = 0;
    logic [NS-1:0] rsp_strb;

    // Transaction-level prediction of one bus access
    task automatic model(input logic wr, input logic [AWP-1:0] addr, input logic [31:0] wd,
                         input int delay, input logic [31:0] sdata,
                         output logic [31:0] rd, output logic e, output int lat,
                         output logic [NS-1:0] smask, output int held);
        int w;
        bit tmo;
        w = int'(addr) / 4;
        rd = '0; e = 1'b0; lat = 1; smask = '0; held = 0; tmo = 1'b0;
        if (w < NS) begin
            smask[w] = 1'b1;
`ifdef BUS_TIMEOUT_EN
            tmo = (delay >= TMO);
`endif
            if (tmo) begin
                e = 1'b1; lat = TMO + 1; held = TMO;
            end else begin
                lat = delay + 2; held = delay + 1;
                rd = wr ? 32'h0 : sdata;
            end
        end else if (w == NS) begin
            if (wr) pend_m = pend_m & ~wd[7:0];
            else    rd = 32'(pend_m);
        end else if (w == NS + 1) begin
            if (wr) mask_m = wd[7:0];
            else    rd = 32'(mask_m);
        end else if (w == NS + 2) begin
            if (wr) begin ecnt_m = '0; lastw_m = '0; end
            else    rd = {11'd0, lastw_m, ecnt_m};
        end else begin
            e = 1'b1;
        end
        if (e) begin
            if (ecnt_m != 16'hFFFF) ecnt_m = ecnt_m + 16'd1;
            lastw_m = 5'(w);
        end
    endtask

    // Issue one transfer and wait (bounded) for it to complete
    task automatic xfer(input logic we_i, input logic re_i, input logic [AWP-1:0] addr,
                        input logic [31:0] wd, input int delay, input logic [31:0] sdata,
                        input logic [NS-1:0] src_rise);
        exp_t e;
        logic [NS-1:0] sm;
        int held;
        int budget;
        model(we_i, addr, wd, delay, sdata, e.rd, e.err, e.lat, sm, held);
        pend_m = pend_m | (8'(src_rise) & ~8'(irq_src));
        @(negedge clk);
        rsp_mask = sm; rsp_wr = we_i; rsp_wd = wd; rsp_data = sdata;
        rsp_delay = delay; rsp_held = 0;
        e.issue = cyc;
        sb.push_back(e);
        A = addr; WD = wd; WE = we_i; RE = re_i;
        irq_src = irq_src | src_rise;
        @(posedge clk);
        #1;
        WE = 1'b0; RE = 1'b0;
        budget = 0;
        while (!(sb.size() == 0 && busy == 1'b0)) begin
            @(negedge clk);
            // Requests while busy must be ignored
            if (busy && $urandom_range(0, 3) == 0) begin
                A = AWP'($urandom); WD = $urandom; WE = 1'($urandom); RE = 1'($urandom);
            end else begin
                WE = 1'b0; RE = 1'b0;
            end
            budget++;
            if (budget > 60) begin
                n_vec++; n_fail++;
                $display("FAIL xfer_timeout: addr 0x%02h no completion after %0d cycles, expected latency %0d",
                         addr, budget, e.lat);
                finish_bench();
            end
        end
        if (sm != '0) chk("strobe_cycles", 32'(rsp_held), 32'(held));
        chk("irq", 32'(irq), 32'(|(pend_m & mask_m)));
        rsp_mask = '0;
    endtask

    // Slot responder: drives junk everywhere, acks the active slot after rsp_delay
    always @(negedge clk) begin
        rsp_strb = slv_we | slv_re;
        for (int k = 0; k < NS; k++) slv_rd[32*k +: 32] = $urandom;
        slv_ack = NS'($urandom & $urandom);
        if (rst_n && rsp_strb != '0) begin
            chk("slv_we", 32'(slv_we), rsp_wr ? 32'(rsp_mask) : 32'h0);
            chk("slv_re", 32'(slv_re), rsp_wr ? 32'h0 : 32'(rsp_mask));
            if (rsp_wr) chk("slv_wd", slv_wd, rsp_wd);
            slv_ack = slv_ack & ~rsp_mask;
            for (int k = 0; k < NS; k++) if (rsp_mask[k]) slv_rd[32*k +: 32] = rsp_data;
            if (rsp_cnt == rsp_delay) slv_ack = slv_ack | rsp_mask;
            rsp_cnt++;
            rsp_held = rsp_cnt;
        end else begin
            rsp_cnt = 0;
        end
    end

    // Monitor: every ready pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (sb.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL unexpected_ready: got ready=1 RD=0x%08h, expected no response", RD);
            end else begin
                mon_e = sb.pop_front();
                chk("rd", RD, mon_e.rd);
                chk("err", 32'(err), 32'(mon_e.err));
                chk("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
                chk("busy_at_ready", 32'(busy), 32'h1);
            end
        end else if (rst_n) begin
            chk("err_without_ready", 32'(err), 32'h0);
        end
    end

    task automatic reset_model();
        pend_m = '0; mask_m = '0; ecnt_m = '0; lastw_m = '0;
    endtask

    // Reset during WAIT aborts the transfer with no response
    task automatic reset_mid();
        @(negedge clk);
        rsp_mask = 8'h20; rsp_wr = 1'b0; rsp_delay = 1000; rsp_data = '0;
        A = 6'h14; RE = 1'b1;
        @(posedge clk);
        #1;
        RE = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        irq_src = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_slv_we", 32'(slv_we), 32'h0);
        chk("rst_slv_re", 32'(slv_re), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        reset_model();
        rsp_mask = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(ready), 32'h0);
            chk("post_rst_busy", 32'(busy), 32'h0);
        end
    endtask

    initial begin
        #500000;
        n_vec++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected bench completion");
        finish_bench();
    end

    initial begin
        int w;
        logic we_r, re_r;
        int dly;
        rst_n = 1'b0; A = '0; WD = '0; WE = 1'b0; RE = 1'b0; irq_src = '0;
        slv_ack = '0; slv_rd = '0;
        reset_model();
        repeat (2) @(negedge clk);
        chk("reset_RD", RD, 32'h0);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_slv_we", 32'(slv_we), 32'h0);
        chk("reset_slv_re", 32'(slv_re), 32'h0);
        chk("reset_slv_wd", slv_wd, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        // Slot write held for three cycles, slot read with immediate ack
        xfer(1'b1, 1'b0, 6'h0C, 32'h1234, 2, 32'h0, '0);
        xfer(1'b0, 1'b1, 6'h04, 32'h0, 0, 32'hCAFEF00D, '0);
        // WE and RE together behave as a write
        xfer(1'b1, 1'b1, 6'h18, 32'h5A5A5A5A, 1, 32'h11112222, '0);

`ifdef BUS_TIMEOUT_EN
        xfer(1'b1, 1'b0, 6'h28, 32'hFFFFFFFF, 0, 32'h0, '0);
        xfer(1'b0, 1'b1, 6'h08, 32'h0, 100, 32'hDEADBEEF, '0);
        xfer(1'b0, 1'b1, 6'h28, 32'h0, 0, 32'h0, '0);
        xfer(1'b0, 1'b1, 6'h1C, 32'h0, TMO - 1, 32'h0BADC0DE, '0);
        xfer(1'b1, 1'b0, 6'h10, 32'h77, TMO, 32'h0, '0);
`endif

        // Unmapped access and the resulting statistics
        xfer(1'b0, 1'b1, 6'h3C, 32'h0, 0, 32'h0, '0);
        xfer(1'b1, 1'b0, 6'h30, 32'h99, 0, 32'h0, '0);
        xfer(1'b0, 1'b1, 6'h28, 32'h0, 0, 32'h0, '0);

        // Interrupt path
        xfer(1'b1, 1'b0, 6'h24, 32'h05, 0, 32'h0, '0);
        xfer(1'b0, 1'b1, 6'h24, 32'h0, 0, 32'h0, '0);
        @(negedge clk);
        irq_src[2] = 1'b1;
        pend_m = pend_m | 8'h04;
        @(posedge clk);
        #1;
        chk("irq_lag", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        chk("irq_set", 32'(irq), 32'h1);
        xfer(1'b0, 1'b1, 6'h20, 32'h0, 0, 32'h0, '0);
        xfer(1'b1, 1'b0, 6'h20, 32'h04, 0, 32'h0, 8'h01);
        xfer(1'b0, 1'b1, 6'h20, 32'h0, 0, 32'h0, '0);
        @(negedge clk);
        irq_src[0] = 1'b0;
        xfer(1'b1, 1'b0, 6'h20, 32'h01, 0, 32'h0, 8'h01);
        xfer(1'b0, 1'b1, 6'h20, 32'h0, 0, 32'h0, '0);
        xfer(1'b1, 1'b0, 6'h20, 32'h05, 0, 32'h0, '0);
        xfer(1'b0, 1'b1, 6'h20, 32'h0, 0, 32'h0, '0);

        reset_mid();
        xfer(1'b0, 1'b1, 6'h28, 32'h0, 0, 32'h0, '0);
        xfer(1'b0, 1'b1, 6'h04, 32'h0, 1, 32'h13572468, '0);

        // Randomised traffic over the whole map
        for (int i = 0; i < 250; i++) begin
            w = $urandom_range(0, 15);
            we_r = 1'($urandom);
            re_r = we_r ? 1'($urandom) : 1'b1;
`ifdef BUS_TIMEOUT_EN
            dly = $urandom_range(0, 6);
`else
            dly = $urandom_range(0, 8);
`endif
            xfer(we_r, re_r, AWP'(w * 4 + $urandom_range(0, 3)), $urandom, dly, $urandom, '0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        finish_bench();
    end

endmodule
